// File: rtl/key_evt_arb.sv
// key_evt_arb: latches debounced key presses and issues them one at a
// time, round-robin, with a lockout gap between accepted events.
module key_evt_arb #(
    parameter int N_KEYS  = 4,
    parameter int IDX_W   = 2,
    parameter int GAP_CYC = 1000,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_pulse,
    output logic              evt_valid,
    output logic [IDX_W-1:0]  evt_idx,
    input  logic              evt_ready,
    output logic [N_KEYS-1:0] pend,
    output logic              ovf,
    input  logic              ovf_clr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_VALID = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    localparam logic [CNT_W-1:0] GAP_LAST =
        (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_KEYS - 1);

    logic [1:0]        st_q, st_d;
    logic              vld_q, vld_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_KEYS-1:0] pend_q, pend_d;
    logic              ovf_q, ovf_d;

    logic              hs;
    logic [N_KEYS-1:0] clr;
    logic              pick_ok;
    logic [IDX_W-1:0]  pick_idx;
    int                cand;

    assign hs  = vld_q & evt_ready;
    assign clr = hs ? (N_KEYS'(1) << idx_q) : '0;

    // Round-robin pick: first pending key above last_grant, wrapping at N_KEYS.
    always_comb begin
        pick_ok  = 1'b0;
        pick_idx = '0;
        cand     = 0;
        for (int k = N_KEYS; k >= 1; k--) begin
            cand = int'(last_q) + k;
            if (cand >= N_KEYS) begin
                cand = cand - N_KEYS;
            end
            if (pend_q[cand]) begin
                pick_ok  = 1'b1;
                pick_idx = IDX_W'(cand);
            end
        end
    end

    // Pending flags and sticky overflow; a fresh press beats the clear.
    always_comb begin
        pend_d = (pend_q & ~clr) | key_pulse;
        ovf_d  = ovf_q;
        if (|(key_pulse & pend_q & ~clr)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Issue FSM: present, wait for handshake, then sit out the lockout gap.
    always_comb begin
        st_d   = st_q;
        vld_d  = vld_q;
        idx_d  = idx_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        case (st_q)
            S_IDLE: begin
                if (pick_ok) begin
                    idx_d = pick_idx;
                    vld_d = 1'b1;
                    st_d  = S_VALID;
                end
            end
            S_VALID: begin
                if (hs) begin
                    vld_d  = 1'b0;
                    last_d = idx_q;
                    cnt_d  = '0;
                    st_d   = (GAP_CYC == 0) ? S_IDLE : S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    st_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                st_d  = S_IDLE;
                vld_d = 1'b0;
                cnt_d = '0;
            end
        endcase
    end

    // State registers; reset drops any presented event and pending presses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= S_IDLE;
            vld_q  <= 1'b0;
            idx_q  <= '0;
            last_q <= LAST_RST;
            cnt_q  <= '0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            vld_q  <= vld_d;
            idx_q  <= idx_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign evt_valid = vld_q;
    assign evt_idx   = idx_q;
    assign pend      = pend_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_evt_arb.sv
// tb_key_evt_arb: two arbiters (gap 0 and gap 5) on shared stimulus,
// compared every cycle against an event-level reference model.
module tb_key_evt_arb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_pulse = '0;
    logic       evt_ready = 1'b0;
    logic       ovf_clr = 1'b0;

    logic       v0, v1, o0, o1;
    logic [1:0] i0, i1;
    logic [3:0] p0, p1;

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    key_evt_arb #(.N_KEYS(4), .IDX_W(2), .GAP_CYC(0), .CNT_W(16)) u_g0 (
        .clk(clk), .rst(rst), .key_pulse(key_pulse),
        .evt_valid(v0), .evt_idx(i0), .evt_ready(evt_ready),
        .pend(p0), .ovf(o0), .ovf_clr(ovf_clr)
    );

    key_evt_arb #(.N_KEYS(4), .IDX_W(2), .GAP_CYC(5), .CNT_W(16)) u_g5 (
        .clk(clk), .rst(rst), .key_pulse(key_pulse),
        .evt_valid(v1), .evt_idx(i1), .evt_ready(evt_ready),
        .pend(p1), .ovf(o1), .ovf_clr(ovf_clr)
    );

    // reference model state, one slot per DUT
    longint     cyc = 0;
    logic [3:0] m_pend [2];
    logic       m_ovf  [2];
    logic       m_vld  [2];
    int         m_idx  [2];
    int         m_last [2];
    longint     m_ok   [2];
    int         m_gap  [2] = '{0, 5};

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = '0;
            m_ovf[d]  = 1'b0;
            m_vld[d]  = 1'b0;
            m_idx[d]  = 0;
            m_last[d] = 3;
            m_ok[d]   = 0;
        end
    endtask

    task automatic model_edge(input int d, input logic [3:0] kp,
                              input logic rdy, input logic oc);
        logic [3:0] old;
        logic [3:0] clr;
        int         c;
        old = m_pend[d];
        clr = '0;
        if (m_vld[d] && rdy) begin
            clr[m_idx[d]] = 1'b1;
            m_vld[d]  = 1'b0;
            m_last[d] = m_idx[d];
            m_ok[d]   = cyc + 1 + m_gap[d];
        end else if (!m_vld[d] && cyc >= m_ok[d] && old != 0) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_last[d] + k) % 4;
                if (!m_vld[d] && old[c]) begin
                    m_idx[d] = c;
                    m_vld[d] = 1'b1;
                end
            end
        end
        if ((kp & old & ~clr) != 0) m_ovf[d] = 1'b1;
        else if (oc) m_ovf[d] = 1'b0;
        m_pend[d] = (old & ~clr) | kp;
    endtask

    task automatic cmp_all(input string tag);
        check({tag, " g0 valid"}, 32'(v0), 32'(m_vld[0]));
        check({tag, " g0 idx"},   32'(i0), 32'(m_idx[0]));
        check({tag, " g0 pend"},  32'(p0), 32'(m_pend[0]));
        check({tag, " g0 ovf"},   32'(o0), 32'(m_ovf[0]));
        check({tag, " g5 valid"}, 32'(v1), 32'(m_vld[1]));
        check({tag, " g5 idx"},   32'(i1), 32'(m_idx[1]));
        check({tag, " g5 pend"},  32'(p1), 32'(m_pend[1]));
        check({tag, " g5 ovf"},   32'(o1), 32'(m_ovf[1]));
    endtask

    task automatic step(input string tag, input logic [3:0] kp,
                        input logic rdy, input logic oc, input bit r);
        @(negedge clk);
        key_pulse = kp;
        evt_ready = rdy;
        ovf_clr   = oc;
        if (r) begin
            #2 rst = 1'b1;
            #1;
            model_reset();
            cmp_all({tag, " async rst"});
            #1 rst = 1'b0;
        end
        @(posedge clk);
        model_edge(0, kp, rdy, oc);
        model_edge(1, kp, rdy, oc);
        cyc++;
        #1 cmp_all(tag);
    endtask

    initial begin
        logic [3:0] kp;
        model_reset();
        repeat (2) @(posedge clk);
        #1 cmp_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // single press on key 2
        step("single", 4'b0100, 1'b1, 1'b0, 1'b0);
        repeat (10) step("single", 4'b0000, 1'b1, 1'b0, 1'b0);

        // all keys at once, then keys 0 and 3
        step("all", 4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (30) step("all", 4'b0000, 1'b1, 1'b0, 1'b0);
        step("rr03", 4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (4) step("rr03", 4'b0000, 1'b1, 1'b0, 1'b0);
        step("rr03", 4'b1001, 1'b1, 1'b0, 1'b0);
        repeat (20) step("rr03", 4'b0000, 1'b1, 1'b0, 1'b0);

        // backpressure
        step("bp", 4'b0001, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 50; k++) begin
            kp = (k == 10) ? 4'b0010 : (k == 20) ? 4'b1000 : 4'b0000;
            step("bp", kp, 1'b0, 1'b0, 1'b0);
        end
        repeat (30) step("bp", 4'b0000, 1'b1, 1'b0, 1'b0);

        // overflow on a pending, not presented key
        step("ovf", 4'b0001, 1'b0, 1'b0, 1'b0);
        repeat (3) step("ovf", 4'b0000, 1'b0, 1'b0, 1'b0);
        step("ovf", 4'b0010, 1'b0, 1'b0, 1'b0);
        step("ovf", 4'b0010, 1'b0, 1'b0, 1'b0);
        step("ovf", 4'b0000, 1'b0, 1'b1, 1'b0);
        repeat (20) step("ovf", 4'b0000, 1'b1, 1'b0, 1'b0);

        // press on key 1 in the cycle of its own handshake
        step("coll", 4'b0010, 1'b0, 1'b0, 1'b0);
        repeat (3) step("coll", 4'b0000, 1'b0, 1'b0, 1'b0);
        step("coll", 4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (12) step("coll", 4'b0000, 1'b1, 1'b0, 1'b0);

        // reset while presenting, then while in the gap
        step("rstv", 4'b0100, 1'b0, 1'b0, 1'b0);
        repeat (3) step("rstv", 4'b0000, 1'b0, 1'b0, 1'b0);
        step("rstv", 4'b0000, 1'b0, 1'b0, 1'b1);
        step("rstv", 4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (4) step("rstv", 4'b0000, 1'b1, 1'b0, 1'b0);
        step("rstg", 4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (5) step("rstg", 4'b0000, 1'b1, 1'b0, 1'b0);
        step("rstg", 4'b0000, 1'b1, 1'b0, 1'b1);
        step("rstg", 4'b0001, 1'b1, 1'b0, 1'b0);
        repeat (10) step("rstg", 4'b0000, 1'b1, 1'b0, 1'b0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            kp = '0;
            for (int b = 0; b < 4; b++) begin
                kp[b] = ($urandom_range(0, 7) == 0);
            end
            step("rand", kp,
                 $urandom_range(0, 9) < 7,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
